// File: rtl/board_pkg.sv
// board_pkg: definitions shared by the board generator and the board player.
//   - status_e      : game_status encoding
//   - SOLVED_BOARD  : target board 0123
//   - DIR_*         : move directions (the direction the blank moves)
//   - board_valid() : tile range, distinctness and solvability check
package board_pkg;

  localparam int unsigned TILE_W  = 3;
  localparam int unsigned BOARD_W = 4 * TILE_W;

  typedef enum logic [1:0] {
    CHOSE_BOARD  = 2'b00,
    GAMING       = 2'b01,
    GAME_INITIAL = 2'b10,
    WINNED       = 2'b11
  } status_e;

  localparam logic [BOARD_W-1:0] SOLVED_BOARD = 12'b000_001_010_011;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // A board is playable when its tiles are 0..3, all distinct, and the three
  // non-blank tiles read around the ring pos0,pos1,pos3,pos2 are a rotation
  // of (1,3,2) -- the only cyclic order reachable from 0123.
  function automatic logic board_valid(input logic [BOARD_W-1:0] b);
    logic [TILE_W-1:0] t    [4];
    logic [TILE_W-1:0] ring [4];
    logic [1:0]        seq  [3];
    logic [1:0]        n;
    logic [5:0]        s;
    logic              ok;
    t[0] = b[11:9];
    t[1] = b[8:6];
    t[2] = b[5:3];
    t[3] = b[2:0];
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (t[i][2]) ok = 1'b0;
      for (int j = i + 1; j < 4; j++) begin
        if (t[i] == t[j]) ok = 1'b0;
      end
    end
    ring[0] = t[0];
    ring[1] = t[1];
    ring[2] = t[3];
    ring[3] = t[2];
    seq[0] = 2'd0;
    seq[1] = 2'd0;
    seq[2] = 2'd0;
    n = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (ring[k] != '0 && n < 2'd3) begin
        seq[n] = ring[k][1:0];
        n = n + 2'd1;
      end
    end
    s = {seq[0], seq[1], seq[2]};
    return ok && (s == 6'b01_11_10 || s == 6'b11_10_01 || s == 6'b10_01_11);
  endfunction

endpackage

// File: rtl/board_player_if.sv
// board_player_if: board bus between the generator/controls and the player.
//   master : drives board_in, confirm, quit, move_valid, move_dir
//   slave  : the player; drives game_status, board, move_count,
//            illegal_move, bad_board
interface board_player_if #(
  parameter int unsigned CNT_W = 10
);

  logic [11:0]      board_in;
  logic             confirm;
  logic             quit;
  logic             move_valid;
  logic [1:0]       move_dir;
  logic [1:0]       game_status;
  logic [11:0]      board;
  logic [CNT_W-1:0] move_count;
  logic             illegal_move;
  logic             bad_board;

  modport master (
    output board_in, confirm, quit, move_valid, move_dir,
    input  game_status, board, move_count, illegal_move, bad_board
  );

  modport slave (
    input  board_in, confirm, quit, move_valid, move_dir,
    output game_status, board, move_count, illegal_move, bad_board
  );

endinterface

// File: rtl/blank_mover.sv
// blank_mover: combinational move of the blank tile on a 2x2 board.
//   board_i      : current board, pos0=[11:9] TL .. pos3=[2:0] BR
//   dir_i        : direction the blank moves
//   next_board_o : board after the move (equals board_i when illegal)
//   legal_o      : move stays on the grid
//   blank_pos_o  : position of the blank in board_i
module blank_mover
  import board_pkg::*;
(
  input  logic [BOARD_W-1:0] board_i,
  input  logic [1:0]         dir_i,
  output logic [BOARD_W-1:0] next_board_o,
  output logic               legal_o,
  output logic [1:0]         blank_pos_o
);

  logic [TILE_W-1:0] tiles [4];
  logic [TILE_W-1:0] moved [4];
  logic [1:0]        nbr_pos;

  always_comb begin
    tiles[0] = board_i[11:9];
    tiles[1] = board_i[8:6];
    tiles[2] = board_i[5:3];
    tiles[3] = board_i[2:0];

    blank_pos_o = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (tiles[i] == '0) blank_pos_o = 2'(i);
    end

    // Position bit 1 is the row, bit 0 the column: a vertical move flips the
    // row bit, a horizontal move flips the column bit.
    legal_o = 1'b0;
    nbr_pos = blank_pos_o;
    unique case (dir_i)
      DIR_UP: begin
        legal_o = blank_pos_o[1];
        nbr_pos = blank_pos_o ^ 2'b10;
      end
      DIR_DOWN: begin
        legal_o = !blank_pos_o[1];
        nbr_pos = blank_pos_o ^ 2'b10;
      end
      DIR_LEFT: begin
        legal_o = blank_pos_o[0];
        nbr_pos = blank_pos_o ^ 2'b01;
      end
      DIR_RIGHT: begin
        legal_o = !blank_pos_o[0];
        nbr_pos = blank_pos_o ^ 2'b01;
      end
      default: ;
    endcase

    for (int i = 0; i < 4; i++) begin
      moved[i] = tiles[i];
      if (legal_o) begin
        if (2'(i) == blank_pos_o) moved[i] = tiles[nbr_pos];
        else if (2'(i) == nbr_pos) moved[i] = '0;
      end
    end
    next_board_o = {moved[0], moved[1], moved[2], moved[3]};
  end

endmodule

// File: rtl/board_player.sv
// board_player: owns game_status. Latches and validates the chosen board,
// then plays the 2x2 sliding puzzle from one-cycle move pulses.
//   clk_d, rst : clock and synchronous active-high reset
//   bp         : board bus (slave side) -- board_in and controls in,
//                status/board/move_count/pulses out, all outputs registered
module board_player
  import board_pkg::*;
#(
  parameter int unsigned CNT_W   = 10,
  parameter int unsigned CNT_MAX = 999
) (
  input  logic                 clk_d,
  input  logic                 rst,
  board_player_if.slave        bp
);

  status_e            status_q;
  logic [BOARD_W-1:0] board_q;
  logic [CNT_W-1:0]   count_q;
  logic               illegal_q;
  logic               bad_q;

  logic [BOARD_W-1:0] next_board;
  logic               legal;
  logic [1:0]         blank_pos_unused;

  blank_mover u_blank_mover (
    .board_i      (board_q),
    .dir_i        (bp.move_dir),
    .next_board_o (next_board),
    .legal_o      (legal),
    .blank_pos_o  (blank_pos_unused)
  );

  always_ff @(posedge clk_d) begin
    if (rst) begin
      status_q  <= CHOSE_BOARD;
      board_q   <= SOLVED_BOARD;
      count_q   <= '0;
      illegal_q <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      bad_q     <= 1'b0;
      unique case (status_q)
        CHOSE_BOARD: begin
          // Board previews board_in; a quit alongside confirm cancels the latch.
          board_q <= bp.board_in;
          count_q <= '0;
          if (bp.confirm && !bp.quit) begin
            if (board_valid(bp.board_in)) status_q <= GAME_INITIAL;
            else                          bad_q    <= 1'b1;
          end
        end
        GAME_INITIAL: begin
          if (bp.quit) begin
            status_q <= CHOSE_BOARD;
            count_q  <= '0;
          end else if (board_q == SOLVED_BOARD) begin
            status_q <= WINNED;
          end else begin
            status_q <= GAMING;
          end
        end
        GAMING: begin
          if (bp.quit) begin
            status_q <= CHOSE_BOARD;
            count_q  <= '0;
          end else if (bp.move_valid) begin
            if (legal) begin
              board_q <= next_board;
              if (count_q != CNT_W'(CNT_MAX)) count_q <= count_q + 1'b1;
              if (next_board == SOLVED_BOARD) status_q <= WINNED;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        WINNED: begin
          if (bp.quit || bp.confirm) begin
            status_q <= CHOSE_BOARD;
            count_q  <= '0;
          end
        end
        default: status_q <= CHOSE_BOARD;
      endcase
    end
  end

  assign bp.game_status  = status_q;
  assign bp.board        = board_q;
  assign bp.move_count   = count_q;
  assign bp.illegal_move = illegal_q;
  assign bp.bad_board    = bad_q;

endmodule

// File: tb/tb_board_player.sv
module tb_board_player;

  localparam logic [1:0] CB = 2'b00;
  localparam logic [1:0] GM = 2'b01;
  localparam logic [1:0] GI = 2'b10;
  localparam logic [1:0] WN = 2'b11;

  localparam logic [1:0] UP = 2'b00;
  localparam logic [1:0] DN = 2'b01;
  localparam logic [1:0] LT = 2'b10;
  localparam logic [1:0] RT = 2'b11;

  typedef struct {
    string       name;
    logic [1:0]  status;
    logic [11:0] board;
    int          count;
    logic        ill;
    logic        bad;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  board_player_if #(.CNT_W(10)) bp_if ();

  board_player #(
    .CNT_W   (10),
    .CNT_MAX (999)
  ) dut (
    .clk_d (clk),
    .rst   (rst),
    .bp    (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
    end
  endtask

  // Monitor: outputs are registered, so compare on the falling edge after
  // each expectation was pushed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "status", int'(bp_if.game_status), int'(e.status));
        chk(e.name, "board", int'(bp_if.board), int'(e.board));
        chk(e.name, "count", int'(bp_if.move_count), e.count);
        chk(e.name, "illegal", int'(bp_if.illegal_move), int'(e.ill));
        chk(e.name, "bad", int'(bp_if.bad_board), int'(e.bad));
      end
    end
  end

  // One clock of stimulus, then the state expected after that edge.
  task automatic cyc(input logic r, input logic [11:0] bin, input logic conf,
                     input logic q, input logic mv, input logic [1:0] dir,
                     input string nm, input logic [1:0] es, input logic [11:0] eb,
                     input int ec, input logic ei, input logic ebd);
    exp_t e;
    @(negedge clk);
    rst               = r;
    bp_if.board_in    = bin;
    bp_if.confirm     = conf;
    bp_if.quit        = q;
    bp_if.move_valid  = mv;
    bp_if.move_dir    = dir;
    @(posedge clk);
    #1;
    e.name   = nm;
    e.status = es;
    e.board  = eb;
    e.count  = ec;
    e.ill    = ei;
    e.bad    = ebd;
    sb.push_back(e);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst               = 1'b1;
    bp_if.board_in    = 12'o0123;
    bp_if.confirm     = 1'b0;
    bp_if.quit        = 1'b0;
    bp_if.move_valid  = 1'b0;
    bp_if.move_dir    = UP;

    //  r   board_in  cf   qt   mv   dir  name          status board     cnt ill  bad
    cyc(1, 12'o0123, 0, 0, 0, UP, "reset",        CB, 12'o0123, 0, 0, 0);
    cyc(0, 12'o1023, 1, 0, 0, UP, "latch1023",    GI, 12'o1023, 0, 0, 0);
    cyc(0, 12'o0123, 0, 0, 1, LT, "init_ignmv",   GM, 12'o1023, 0, 0, 0);
    cyc(0, 12'o0123, 0, 0, 1, RT, "ill_right",    GM, 12'o1023, 0, 1, 0);
    cyc(0, 12'o0123, 0, 0, 1, UP, "ill_up",       GM, 12'o1023, 0, 1, 0);
    cyc(0, 12'o0123, 0, 0, 0, UP, "ill_clear",    GM, 12'o1023, 0, 0, 0);
    cyc(0, 12'o0123, 0, 0, 1, DN, "down",         GM, 12'o1320, 1, 0, 0);
    cyc(0, 12'o0123, 0, 0, 1, UP, "up",           GM, 12'o1023, 2, 0, 0);
    cyc(0, 12'o0123, 0, 0, 1, LT, "left_win",     WN, 12'o0123, 3, 0, 0);
    cyc(0, 12'o0123, 0, 0, 1, DN, "win_frozen",   WN, 12'o0123, 3, 0, 0);
    cyc(0, 12'o0123, 1, 0, 0, UP, "win_confirm",  CB, 12'o0123, 0, 0, 0);
    cyc(0, 12'o3023, 1, 0, 0, UP, "bad_dup",      CB, 12'o3023, 0, 0, 1);
    cyc(0, 12'o0132, 1, 0, 0, UP, "bad_unsolv",   CB, 12'o0132, 0, 0, 1);
    cyc(0, 12'o4120, 1, 0, 0, UP, "bad_range",    CB, 12'o4120, 0, 0, 1);
    cyc(0, 12'o0132, 0, 0, 0, UP, "bad_clear",    CB, 12'o0132, 0, 0, 0);
    cyc(0, 12'o1023, 1, 1, 0, UP, "conf_quit",    CB, 12'o1023, 0, 0, 0);
    cyc(0, 12'o1023, 1, 0, 0, UP, "latch_again",  GI, 12'o1023, 0, 0, 0);
    cyc(0, 12'o0123, 0, 0, 0, UP, "to_gaming",    GM, 12'o1023, 0, 0, 0);
    cyc(0, 12'o0123, 0, 0, 1, DN, "mv1",          GM, 12'o1320, 1, 0, 0);
    cyc(0, 12'o0123, 0, 0, 1, UP, "mv2",          GM, 12'o1023, 2, 0, 0);
    cyc(0, 12'o0123, 0, 0, 1, DN, "mv3",          GM, 12'o1320, 3, 0, 0);
    cyc(0, 12'o0123, 0, 0, 1, UP, "mv4",          GM, 12'o1023, 4, 0, 0);
    cyc(0, 12'o0123, 0, 0, 1, DN, "mv5",          GM, 12'o1320, 5, 0, 0);
    cyc(0, 12'o0123, 0, 0, 1, RT, "ill_bottom_r", GM, 12'o1320, 5, 1, 0);
    cyc(1, 12'o0123, 0, 0, 1, UP, "rst_midgame",  CB, 12'o0123, 0, 0, 0);
    cyc(0, 12'o1023, 1, 0, 0, UP, "latch3",       GI, 12'o1023, 0, 0, 0);
    cyc(0, 12'o0123, 0, 0, 0, UP, "to_gaming3",   GM, 12'o1023, 0, 0, 0);
    cyc(0, 12'o0123, 0, 1, 1, DN, "quit_move",    CB, 12'o1023, 0, 0, 0);
    cyc(0, 12'o0123, 1, 0, 0, UP, "latch_solved", GI, 12'o0123, 0, 0, 0);
    cyc(0, 12'o0123, 0, 0, 0, UP, "init_win",     WN, 12'o0123, 0, 0, 0);
    cyc(0, 12'o0123, 0, 1, 0, UP, "win_quit",     CB, 12'o0123, 0, 0, 0);

    @(negedge clk);
    bp_if.confirm    = 1'b0;
    bp_if.quit       = 1'b0;
    bp_if.move_valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
